// File: rtl/neural_pkg.sv
// Shared definitions for the neural core spike queues: default entry widths,
// the packed entry layout and the count constants used by the RLE queue.
package neural_pkg;

    localparam int PAYLOAD_W_DEF = 16;
    localparam int COUNT_W_DEF   = 16;
    localparam int ADDR_LEN_DEF  = 8;

    typedef struct packed {
        logic [PAYLOAD_W_DEF-1:0] payload;
        logic [COUNT_W_DEF-1:0]   count;
    } spike_entry_t;

    localparam logic [COUNT_W_DEF-1:0] COUNT_ZERO = '0;
    localparam logic [COUNT_W_DEF-1:0] COUNT_MAX  = '1;

endpackage

// File: rtl/rle_fifo_mem.sv
// Entry storage for rle_fifo: one full-entry write port, one head-count
// write port and two asynchronous read ports (head and tail-1).
module rle_fifo_mem #(
    parameter int DATA_W   = 32,
    parameter int COUNT_W  = 16,
    parameter int ADDR_LEN = 8
) (
    input  logic                clk,
    input  logic                wr_en_i,
    input  logic [ADDR_LEN-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                cnt_en_i,
    input  logic [ADDR_LEN-1:0] cnt_addr_i,
    input  logic [COUNT_W-1:0]  cnt_data_i,
    input  logic [ADDR_LEN-1:0] head_addr_i,
    output logic [DATA_W-1:0]   head_data_o,
    input  logic [ADDR_LEN-1:0] tail_addr_i,
    output logic [DATA_W-1:0]   tail_data_o
);

    localparam int DEPTH = 1 << ADDR_LEN;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Control guarantees the two write ports never target the same entry.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (cnt_en_i) begin
            mem_q[cnt_addr_i][COUNT_W-1:0] <= cnt_data_i;
        end
    end

    assign head_data_o = mem_q[head_addr_i];
    assign tail_data_o = mem_q[tail_addr_i];

endmodule

// File: rtl/rle_fifo.sv
// Run-length-encoded spike queue: each entry is {payload, repeat count} and a
// dequeue consumes one repetition; optional coalescing into the tail entry.
module rle_fifo
    import neural_pkg::*;
#(
    parameter int PAYLOAD_W   = PAYLOAD_W_DEF,
    parameter int COUNT_W     = COUNT_W_DEF,
    parameter int ADDR_LEN    = ADDR_LEN_DEF,
    parameter bit MERGE       = 1'b1,
    parameter int AFULL_LEVEL = (1 << ADDR_LEN) - 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         enqueue,
    input  logic                         dequeue,
    input  logic [PAYLOAD_W+COUNT_W-1:0] data_in,
    output logic [PAYLOAD_W-1:0]         data_out,
    output logic [COUNT_W-1:0]           head_count,
    output logic [ADDR_LEN:0]            level,
    output logic                         full,
    output logic                         almost_full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int                DEPTH   = 1 << ADDR_LEN;
    localparam int                DATA_W  = PAYLOAD_W + COUNT_W;
    localparam logic [ADDR_LEN:0] FULL_L  = (ADDR_LEN+1)'(DEPTH);
    localparam logic [ADDR_LEN:0] AFULL_L = (ADDR_LEN+1)'(AFULL_LEVEL);

    logic [ADDR_LEN-1:0] head_q, head_d, tail_q, tail_d, tail_m1;
    logic [ADDR_LEN:0]   level_q, level_d;
    logic                empty_q, empty_d, full_q, full_d, afull_q, afull_d;
    logic                ovf_q, ovf_d, udf_q, udf_d;

    logic                wr_en, cnt_en, push, pop, merge_ok;
    logic [ADDR_LEN-1:0] wr_addr;
    logic [DATA_W-1:0]   wr_data, head_entry, tail_entry;
    logic [COUNT_W-1:0]  cnt_data;
    logic [COUNT_W:0]    merge_sum;

    wire [PAYLOAD_W-1:0] in_pay   = data_in[DATA_W-1:COUNT_W];
    wire [COUNT_W-1:0]   in_cnt   = data_in[COUNT_W-1:0];
    wire [COUNT_W-1:0]   head_cnt = head_entry[COUNT_W-1:0];
    wire [COUNT_W-1:0]   tail_cnt = tail_entry[COUNT_W-1:0];

    assign tail_m1   = tail_q - 1'b1;
    assign merge_sum = {1'b0, tail_cnt} + {1'b0, in_cnt};

    // With a single entry and a concurrent dequeue, head and merge target
    // coincide, so a fresh entry is written instead of coalescing.
    assign merge_ok = MERGE && (level_q != '0)
                      && (in_pay == tail_entry[DATA_W-1:COUNT_W])
                      && !merge_sum[COUNT_W]
                      && !((level_q == (ADDR_LEN+1)'(1)) && dequeue);

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        wr_en    = 1'b0;
        wr_addr  = tail_q;
        wr_data  = data_in;
        cnt_en   = 1'b0;
        cnt_data = head_cnt - 1'b1;
        push     = 1'b0;
        pop      = 1'b0;

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (dequeue) begin
                if (empty_q) begin
                    udf_d = 1'b1;
                end else if (head_cnt == COUNT_W'(1)) begin
                    pop = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            if (enqueue && (in_cnt != '0)) begin
                if (merge_ok) begin
                    wr_en   = 1'b1;
                    wr_addr = tail_m1;
                    wr_data = {in_pay, merge_sum[COUNT_W-1:0]};
                end else if (!full_q || pop) begin
                    wr_en = 1'b1;
                    push  = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            head_d  = head_q + ADDR_LEN'(pop);
            tail_d  = tail_q + ADDR_LEN'(push);
            level_d = level_q + (ADDR_LEN+1)'(push) - (ADDR_LEN+1)'(pop);
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == FULL_L);
        afull_d = (level_d >= AFULL_L);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    rle_fifo_mem #(
        .DATA_W   (DATA_W),
        .COUNT_W  (COUNT_W),
        .ADDR_LEN (ADDR_LEN)
    ) u_mem (
        .clk         (clk),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .cnt_en_i    (cnt_en),
        .cnt_addr_i  (head_q),
        .cnt_data_i  (cnt_data),
        .head_addr_i (head_q),
        .head_data_o (head_entry),
        .tail_addr_i (tail_m1),
        .tail_data_o (tail_entry)
    );

    assign data_out    = empty_q ? '0 : head_entry[DATA_W-1:COUNT_W];
    assign head_count  = empty_q ? '0 : head_cnt;
    assign level       = level_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign empty       = empty_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_rle_fifo.sv
// Self-checking bench for rle_fifo with default parameters (depth 256, merge on).
module tb_rle_fifo;
    import neural_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        enqueue = 1'b0;
    logic        dequeue = 1'b0;
    logic [31:0] data_in = '0;
    logic [15:0] data_out, head_count;
    logic [8:0]  level;
    logic        full, almost_full, empty, overflow, underflow;

    int n_checks = 0;
    int n_errors = 0;

    rle_fifo dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .enqueue     (enqueue),
        .dequeue     (dequeue),
        .data_in     (data_in),
        .data_out    (data_out),
        .head_count  (head_count),
        .level       (level),
        .full        (full),
        .almost_full (almost_full),
        .empty       (empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input bit enq, input bit deq, input logic [15:0] pay, input logic [15:0] cnt);
        spike_entry_t e;
        e.payload = pay;
        e.count   = cnt;
        @(negedge clk);
        enqueue = enq;
        dequeue = deq;
        data_in = e;
        @(posedge clk);
        #1;
        enqueue = 1'b0;
        dequeue = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    logic [15:0] sb[$];
    int sent, rcvd, cyc;
    bit  e_i, d_i;

    initial begin
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_hcnt", head_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // single entry with count 3 drained by three dequeues
        op(1, 0, 16'h0005, 16'd3);
        chk("enq_level", level, 1);
        chk("enq_dout", data_out, 16'h0005);
        chk("enq_hcnt", head_count, 3);
        op(0, 1, '0, '0);
        chk("deq1_hcnt", head_count, 2);
        chk("deq1_dout", data_out, 16'h0005);
        op(0, 1, '0, '0);
        chk("deq2_hcnt", head_count, 1);
        chk("deq2_level", level, 1);
        op(0, 1, '0, '0);
        chk("deq3_empty", empty, 1);
        chk("deq3_level", level, 0);
        chk("deq3_hcnt", head_count, 0);

        // tail coalescing and its interruption
        op(1, 0, 16'h0007, 16'd2);
        op(1, 0, 16'h0007, 16'd4);
        chk("merge_level", level, 1);
        chk("merge_hcnt", head_count, 6);
        op(1, 0, 16'h0008, 16'd1);
        op(1, 0, 16'h0007, 16'd1);
        chk("nomerge_level", level, 3);
        chk("nomerge_hcnt", head_count, 6);
        // saturation: 0xFFFF + 1 would overflow the count, so a new entry
        op(1, 0, 16'h0007, 16'hFFFF);
        chk("sat_level", level, 4);
        do_clear();
        chk("clr_level", level, 0);
        chk("clr_empty", empty, 1);

        // zero-count enqueue is silently dropped
        op(1, 0, 16'h0009, 16'd0);
        chk("zero_level", level, 0);
        chk("zero_ovf", overflow, 0);

        // fill to full, checking almost_full threshold along the way
        for (int i = 0; i < 256; i++) begin
            op(1, 0, 16'(i + 16'h100), 16'd1);
            chk("fill_afull", almost_full, (i + 1) >= 252);
            chk("fill_full", full, (i + 1) == 256);
        end
        chk("fill_level", level, 256);
        op(1, 0, 16'hABCD, 16'd1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_level", level, 256);
        op(1, 1, 16'h2000, 16'd1);
        chk("fullpop_level", level, 256);
        chk("fullpop_full", full, 1);
        chk("fullpop_dout", data_out, 16'h0101);
        do_clear();
        chk("clr_ovf", overflow, 0);
        chk("clr_full", full, 0);

        // underflow on empty
        op(0, 1, '0, '0);
        chk("udf_flag", underflow, 1);
        chk("udf_level", level, 0);
        chk("udf_empty", empty, 1);
        do_clear();
        chk("clr_udf", underflow, 0);

        // merge suppressed when the single entry is being dequeued
        op(1, 0, 16'h0003, 16'd2);
        op(1, 1, 16'h0003, 16'd1);
        chk("sup_hcnt", head_count, 1);
        chk("sup_level", level, 2);
        op(0, 1, '0, '0);
        chk("sup_pop_level", level, 1);
        chk("sup_pop_dout", data_out, 16'h0003);
        chk("sup_pop_hcnt", head_count, 1);
        do_clear();

        // random push/pop stream with scoreboard, wraps the pointers
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 600 && cyc < 20000) begin
            cyc++;
            @(negedge clk);
            e_i = (sent < 600) && (sb.size() < 255) && ($urandom_range(0, 2) != 0);
            d_i = (sb.size() > 0) && ($urandom_range(0, 2) != 0);
            if (d_i) begin
                chk("sb_dout", data_out, sb[0]);
                chk("sb_hcnt", head_count, 1);
                void'(sb.pop_front());
                rcvd++;
            end
            if (e_i) begin
                sb.push_back(16'(sent));
                sent++;
            end
            enqueue = e_i;
            dequeue = d_i;
            data_in = {16'(sent - 1), 16'd1};
            @(posedge clk);
            #1;
            enqueue = 1'b0;
            dequeue = 1'b0;
            chk("sb_level", level, sb.size());
        end
        chk("sb_done", rcvd, 600);

        // asynchronous reset mid-stream
        op(1, 0, 16'h0042, 16'd5);
        op(1, 0, 16'h0043, 16'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_dout", data_out, 0);
        chk("arst_hcnt", head_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
